// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: funct3 access codes, FSM states,
// byte-enable patterns and access-size helpers.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_H_LO = 4'b0011;
  localparam logic [3:0] BE_H_HI = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Reserved funct3 codes fall into the word bucket.
  function automatic size_t acc_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (acc_size(f3))
      SZ_B:    return lo;
      SZ_H:    return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (acc_size(f3))
      SZ_H:    return lo[0];
      SZ_W:    return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load extraction: picks the addressed byte/halfword out of a memory word and
// sign- or zero-extends it; purely combinational, no backpressure.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'b0, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_HU:   data = {16'b0, half_v};
      F3_W:    data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: ALU results retire in 1 cycle, loads/stores in 2+ cycles via req/gnt/rvalid;
// ex_ready is low while an access is outstanding. MEM_MISALIGN_TRAP_EN turns misalignment into a trap.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int Size = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [Size-1:0] ex_alu_out,
  input  logic [Size-1:0] ex_rs2_data,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [Size-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [Size-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [Size-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [Size-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic            misalign_trap
);

  state_t          state_q, state_d;
  logic            mem_op, mis, ld_done, st_done;
  logic [1:0]      lo_d, lo_q;
  logic [3:0]      be_d, be_q;
  logic [Size-1:0] wdata_d, wdata_q, addr_q, ld_data;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            rw_q, we_q;

  assign mem_op = ex_mem_read | ex_mem_write;
  assign lo_d   = align_lo(ex_funct3, ex_alu_out[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
  logic trap_q;
  assign mis = misaligned(ex_funct3, ex_alu_out[1:0]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= ex_ready && ex_valid && mem_op && mis;
  end
  assign misalign_trap = trap_q;
`else
  assign mis           = 1'b0;
  assign misalign_trap = 1'b0;
`endif

  always_comb begin
    be_d    = BE_W;
    wdata_d = ex_rs2_data;
    case (acc_size(ex_funct3))
      SZ_B: begin
        be_d    = BE_B << lo_d;
        wdata_d = {4{ex_rs2_data[7:0]}};
      end
      SZ_H: begin
        be_d    = lo_d[1] ? BE_H_HI : BE_H_LO;
        wdata_d = {2{ex_rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ex_ready = 1'b0;
    dmem_req = 1'b0;
    case (state_q)
      IDLE: begin
        ex_ready = 1'b1;
        if (ex_valid && mem_op && !mis) state_d = REQ;
      end
      REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt) state_d = (we_q || dmem_rvalid) ? IDLE : WAIT;
      end
      WAIT: if (dmem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign st_done = (state_q == REQ) && dmem_gnt && we_q;
  assign ld_done = ((state_q == REQ) && dmem_gnt && !we_q && dmem_rvalid) ||
                   ((state_q == WAIT) && dmem_rvalid);

  mem_load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (lo_q),
    .funct3  (f3_q),
    .data    (ld_data)
  );

  // Holding registers double as the dmem request outputs, so they stay stable until gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      lo_q         <= '0;
      f3_q         <= '0;
      rd_q         <= '0;
      rw_q         <= 1'b0;
      we_q         <= 1'b0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (ex_ready && ex_valid) begin
        if (mem_op && !mis) begin
          addr_q  <= {ex_alu_out[Size-1:2], 2'b00};
          wdata_q <= wdata_d;
          be_q    <= be_d;
          lo_q    <= lo_d;
          f3_q    <= ex_funct3;
          rd_q    <= ex_rd;
          rw_q    <= ex_reg_write;
          we_q    <= ex_mem_write;
        end else begin
          wb_valid     <= 1'b1;
          wb_data      <= ex_alu_out;
          wb_rd        <= ex_rd;
          wb_reg_write <= ex_reg_write && !mem_op;
        end
      end
      if (st_done || ld_done) begin
        wb_valid     <= 1'b1;
        wb_rd        <= rd_q;
        wb_reg_write <= rw_q && !we_q;
        if (ld_done) wb_data <= ld_data;
      end
    end
  end

  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule
